// File: rtl/cnn_tx_pkg.sv
// ---------------------------------------------------------------------------
// cnn_tx_pkg
// Shared types and constants for the CNN result transmit path.
//   tx_state_t       : UART hand-off FSM states (IDLE, LOAD, WAIT, DRAIN)
//   NUM_BITS_DEF     : result bits per frame for a 26x26 feature map
//   FIFO_DEPTH_DEF   : default byte FIFO depth
//   bytes_per_frame  : number of bytes needed to carry n result bits
// ---------------------------------------------------------------------------
package cnn_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } tx_state_t;

    localparam int NUM_BITS_DEF   = 676;
    localparam int FIFO_DEPTH_DEF = 4;

    function automatic int bytes_per_frame(input int n);
        return (n + 7) / 8;
    endfunction

endpackage

// File: rtl/cnn_tx_fifo.sv
// ---------------------------------------------------------------------------
// cnn_tx_fifo
// Small synchronous FIFO shared by the CNN byte input and result output paths.
// Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width).
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (empties the FIFO)
//   clr    in   synchronous flush; overrides push and pop in the same cycle
//   push   in   write din (ignored when full)
//   din    in   write data
//   pop    in   discard head entry (ignored when empty)
//   dout   out  head entry, valid whenever empty=0
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored entries
// ---------------------------------------------------------------------------
module cnn_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [AW:0] FULL_CNT = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cnn_result_tx.sv
// ---------------------------------------------------------------------------
// cnn_result_tx
// Packs the 1-bit result stream of cnn_core into bytes (LSB = first bit
// received), buffers them in a byte FIFO and hands them to the UART
// transmitter over the trmt / tx_data / tx_done handshake. One frame is
// NUM_BITS result bits; the last byte of a frame is zero-padded.
//
// Optional feature, macro CNN_RESULT_TX_CHKSUM_EN: when defined, an 8-bit
// mod-256 sum of the frame's data bytes is appended as one extra byte and
// frame_done follows that byte instead of the final data byte.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   bit_vld     in   result bit valid
//   bit_in      in   result bit
//   bit_rdy     out  a bit can be accepted this cycle
//   frame_clr   in   abort current frame, flush packer and FIFO
//   trmt        out  one-cycle pulse: UART starts sending tx_data
//   tx_data     out  byte to transmit, stable until next trmt
//   tx_done     in   UART finished the current byte
//   bsy         out  frame in progress
//   frame_done  out  one-cycle pulse after the frame's final byte completes
// ---------------------------------------------------------------------------
module cnn_result_tx
    import cnn_tx_pkg::*;
#(
    parameter int NUM_BITS   = NUM_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_vld,
    input  logic       bit_in,
    output logic       bit_rdy,
    input  logic       frame_clr,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       bsy,
    output logic       frame_done
);

    localparam int         CW       = $clog2(FIFO_DEPTH);
    localparam logic [9:0] LAST_BIT = 10'(NUM_BITS - 1);

    // Packer
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [7:0] byte_val;
    logic [2:0] bit_cnt_reg;
    logic [9:0] frame_cnt_reg;
    logic       accept;
    logic       last_bit;
    logic       byte_done;
    logic       clr_byte;

    // Transmit FSM
    tx_state_t  state_reg;
    logic       trmt_reg;
    logic [7:0] tx_data_reg;
    logic       frame_done_reg;
    logic       last_sent_reg;

    // FIFO entries are {end-of-frame flag, byte}
    logic       fifo_push;
    logic       fifo_pop;
    logic [8:0] fifo_din;
    logic [8:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CW:0] fifo_count;

    assign last_bit  = (frame_cnt_reg == LAST_BIT);
    assign accept    = bit_vld && bit_rdy && !frame_clr;
    assign byte_done = accept && ((bit_cnt_reg == 3'd7) || last_bit);
    // The shift register is zeroed after every push, so bits above bit_cnt
    // are always 0 and the final short byte comes out zero-padded.
    assign clr_byte  = frame_clr || byte_done;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pack
            assign byte_val[gi]   = (bit_cnt_reg == 3'(gi)) ? bit_in : shift_reg[gi];
            assign shift_next[gi] = clr_byte ? 1'b0
                                  : ((accept && (bit_cnt_reg == 3'(gi))) ? bit_in : shift_reg[gi]);
        end
    endgenerate

`ifdef CNN_RESULT_TX_CHKSUM_EN
    logic       chk_pend_reg;
    logic [7:0] sum_reg;
    logic       chk_push;

    // Input is held off while the checksum waits for FIFO space so that a
    // data push can never collide with the checksum push.
    assign bit_rdy   = !fifo_full && !chk_pend_reg;
    assign chk_push  = chk_pend_reg && !fifo_full && !frame_clr;
    assign fifo_push = byte_done || chk_push;
    assign fifo_din  = chk_pend_reg ? {1'b1, sum_reg} : {1'b0, byte_val};

    always_ff @(posedge clk) begin
        if (!rst_n || frame_clr) begin
            chk_pend_reg <= 1'b0;
            sum_reg      <= 8'h00;
        end else if (byte_done) begin
            sum_reg      <= sum_reg + byte_val;
            chk_pend_reg <= last_bit;
        end else if (chk_push) begin
            sum_reg      <= 8'h00;
            chk_pend_reg <= 1'b0;
        end
    end

    assign bsy = (bit_cnt_reg != 3'd0) || (frame_cnt_reg != 10'd0) ||
                 (fifo_count != '0) || (state_reg != IDLE) || chk_pend_reg;
`else
    assign bit_rdy   = !fifo_full;
    assign fifo_push = byte_done;
    assign fifo_din  = {last_bit, byte_val};

    assign bsy = (bit_cnt_reg != 3'd0) || (frame_cnt_reg != 10'd0) ||
                 (fifo_count != '0) || (state_reg != IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg     <= 8'h00;
            bit_cnt_reg   <= 3'd0;
            frame_cnt_reg <= 10'd0;
        end else begin
            shift_reg <= shift_next;
            if (frame_clr) begin
                bit_cnt_reg   <= 3'd0;
                frame_cnt_reg <= 10'd0;
            end else if (accept) begin
                bit_cnt_reg   <= byte_done ? 3'd0 : bit_cnt_reg + 3'd1;
                frame_cnt_reg <= last_bit ? 10'd0 : frame_cnt_reg + 10'd1;
            end
        end
    end

    cnn_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_clr),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_pop = (state_reg == LOAD) && !frame_clr;

    // Hand-off FSM. A byte popped in LOAD is owned by the UART until
    // tx_done; an abort during that time parks in DRAIN so no new trmt is
    // issued before the UART is free again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            trmt_reg       <= 1'b0;
            tx_data_reg    <= 8'h00;
            frame_done_reg <= 1'b0;
            last_sent_reg  <= 1'b0;
        end else begin
            trmt_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!frame_clr && !fifo_empty) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (frame_clr) begin
                        state_reg <= DRAIN;
                    end else begin
                        trmt_reg      <= 1'b1;
                        tx_data_reg   <= fifo_dout[7:0];
                        last_sent_reg <= fifo_dout[8];
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (frame_clr) begin
                        state_reg <= DRAIN;
                    end else if (tx_done) begin
                        frame_done_reg <= last_sent_reg;
                        state_reg      <= IDLE;
                    end
                end
                DRAIN: begin
                    if (tx_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign trmt       = trmt_reg;
    assign tx_data    = tx_data_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/cnn_result_tx.md
Name: cnn_result_tx

Overview:
- Transmit-side counterpart of the UART-byte-to-bit-RAM input path. It packs the 1-bit result stream from cnn_core into bytes, LSB first, so bit k of a byte is the k-th bit received.
- Bytes are buffered in a small FIFO and handed to the UART transmitter over the trmt/tx_data/tx_done handshake.
- The block sits between cnn_core and UART in cnn, and frames one full feature map per transfer.

Parameters:
- NUM_BITS, 676, result bits per frame (26x26 map); last byte zero-padded.
- FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- bit_vld  in  1  cnn_core result bit valid
- bit_in  in  1  result bit
- bit_rdy  out  1  block can accept a bit this cycle
- frame_clr  in  1  abort current frame, flush packer/FIFO
- trmt  out  1  one-cycle pulse to UART: start sending tx_data
- tx_data  out  8  byte to transmit, held stable until next trmt
- tx_done  in  1  UART finished current byte
- bsy  out  1  frame in progress (bits pending, FIFO non-empty, or byte in flight)
- frame_done  out  1  one-cycle pulse after the frame's final byte completes

Behaviour:
- Reset (rst_n=0 at posedge clk): trmt=0, tx_data=0x00, bit_rdy=1, bsy=0, frame_done=0, FIFO empty, bit_cnt=0, frame_cnt=0, state IDLE.
- bit_rdy = (FIFO count < FIFO_DEPTH). A bit is accepted when bit_vld && bit_rdy; when bit_rdy=0 the bit is ignored, and the producer must hold it.
- Packer: 8-bit shift register plus 3-bit bit_cnt. An accepted bit is written at index bit_cnt.
- Byte push: on the accepted bit with bit_cnt==7, or on the frame's final bit (frame_cnt==NUM_BITS-1), the byte {bit_in at bit_cnt, earlier bits, zeros above} is pushed the same edge. bit_cnt is then cleared.
- frame_cnt is 10 bits. It wraps to 0 after NUM_BITS-1; later bits start a new frame.
- Simultaneous FIFO push and pop: count unchanged, both occur.
- Tx FSM states: IDLE, LOAD, WAIT, DRAIN.
  - IDLE: FIFO non-empty -> LOAD.
  - LOAD: trmt<=1 and tx_data<=FIFO head for exactly one cycle; pop; -> WAIT.
  - WAIT: tx_done -> IDLE. If the byte just sent was the frame's last, frame_done pulses the cycle after tx_done.
  - DRAIN: entered on frame_clr while in LOAD/WAIT; waits for tx_done with no trmt, then -> IDLE.
- Latency: a byte pushed at edge E gives trmt=1 in the cycle after edge E+2, when the FIFO was empty and state was IDLE. At most one trmt per tx_done.
- tx_done outside WAIT/DRAIN is ignored.
- frame_clr (synchronous) clears packer, bit_cnt, frame_cnt and FIFO; pending partial byte is discarded. It beats a simultaneous bit_vld (bit dropped) and a simultaneous push. FSM goes IDLE from IDLE, DRAIN from LOAD/WAIT.
- rst_n low at any point, including mid-byte, returns everything to reset values. A later tx_done is ignored.
- bsy = (bit_cnt!=0) || (frame_cnt!=0) || FIFO non-empty || state!=IDLE.

Optional Feature:
- Macro CNN_RESULT_TX_CHKSUM_EN.
- Defined: an 8-bit running sum (mod 256) of all data bytes pushed in the frame is appended as one extra byte after the final data byte. It is pushed the edge after the final data push, or delayed while the FIFO is full. frame_done pulses after the checksum byte's tx_done. The sum clears on frame end, frame_clr and reset.
- Undefined: no checksum logic; the frame is exactly ceil(NUM_BITS/8) bytes.

Decomposition:
- Package cnn_tx_pkg: tx_state_t enum {IDLE, LOAD, WAIT, DRAIN}; localparam NUM_BITS_DEF=676; function bytes_per_frame(n)=(n+7)/8.
- Sub-module cnn_tx_fifo (synchronous FIFO, DEPTH/WIDTH params, push/pop/clr, full/empty/count). It is shared later with the input path.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-activity -> trmt=0, tx_data=0x00, bit_rdy=1, bsy=0, frame_done=0; a subsequent stray tx_done produces no trmt.
- Bits 1,0,1,1,0,0,0,1 (first->last), NUM_BITS=8 -> one trmt with tx_data=0x8D; tx_done 10 cycles later -> frame_done pulse next cycle, bsy=0.
- 676 ones, NUM_BITS=676 -> 84 bytes 0xFF then 0x0F, 85 trmt pulses; with CNN_RESULT_TX_CHKSUM_EN an 86th byte 0xBB, frame_done after it only.
- Back-pressure: tx_done held 0, 48 bits offered -> bit_rdy=0 after the 40th accepted bit (1 byte in flight + 4 in FIFO); releasing tx_done restores bit_rdy the cycle after pop.
- frame_clr during WAIT with 3 bits packed -> partial byte discarded, state DRAIN, no trmt until tx_done, then normal operation from frame_cnt=0.
- Push/pop collision: 8th bit accepted in the same cycle as LOAD pop with count=1 -> count stays 1, next byte emitted correctly.
